// File: rtl/sha256_pkg.sv
// sha256_pkg: shared state encoding, round/block constants and block-count helper for the SHA-256 controller
package sha256_pkg;
  typedef enum logic [2:0] {IDLE, INIT, LOAD, ROUND, ACCUM, DONE} sha256_state_t;
  localparam int SHA256_ROUNDS = 64;
  localparam int SHA256_BLOCK_BITS = 512;
  function automatic int num_blocks(input int padded_size);
    return (padded_size / SHA256_BLOCK_BITS < 1) ? 1 : padded_size / SHA256_BLOCK_BITS;
  endfunction
endpackage

// File: rtl/sha256_rnd_cnt.sv
// sha256_rnd_cnt: 6-bit compression round counter that saturates at the last round
module sha256_rnd_cnt
  import sha256_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  output logic [5:0] round,
  output logic       last
);
  assign last = round == 6'(SHA256_ROUNDS - 1);
  always_ff @(posedge clk) begin
    if (!reset) round <= '0;
    else if (clr) round <= '0;
    else if (en && !last) round <= round + 6'd1;
  end
endmodule

// File: rtl/sha256_ctrl.sv
// sha256_ctrl: SHA-256 block/round sequencer with start re-arm; optional abort port via SHA256_CTRL_ABORT_EN
module sha256_ctrl
  import sha256_pkg::*;
#(
  parameter  int MSG_SIZE    = 120,
  parameter  int PADDED_SIZE = 512,
  localparam int NUM_BLOCKS  = num_blocks(PADDED_SIZE),
  localparam int BW          = NUM_BLOCKS > 1 ? $clog2(NUM_BLOCKS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
`ifdef SHA256_CTRL_ABORT_EN
  input  logic          abort,
`endif
  output logic          busy,
  output logic          done,
  output logic          hash_valid,
  output logic          init_hash,
  output logic          load_block,
  output logic [BW-1:0] blk_idx,
  output logic          round_en,
  output logic [5:0]    round,
  output logic          accum_en
);
  if (MSG_SIZE + 65 > PADDED_SIZE || PADDED_SIZE % SHA256_BLOCK_BITS != 0) begin : g_bad_size
    $error("sha256_ctrl: PADDED_SIZE does not fit MSG_SIZE or is not a multiple of 512");
  end
  sha256_state_t state, nxt;
  logic armed, accept, last, blk_last, kill;
`ifdef SHA256_CTRL_ABORT_EN
  assign kill = abort && state != IDLE;
`else
  assign kill = 1'b0;
`endif
  assign accept   = state == IDLE && start && armed;
  assign blk_last = blk_idx == BW'(NUM_BLOCKS - 1);
  sha256_rnd_cnt u_rnd (
    .clk   (clk),
    .reset (reset),
    .clr   (load_block),
    .en    (round_en),
    .round (round),
    .last  (last)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = accept ? INIT : IDLE;
      INIT:    nxt = LOAD;
      LOAD:    nxt = ROUND;
      ROUND:   nxt = last ? ACCUM : ROUND;
      ACCUM:   nxt = blk_last ? DONE : LOAD;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (kill) nxt = IDLE;
    busy       = state != IDLE;
    init_hash  = state == INIT;
    load_block = state == LOAD;
    round_en   = state == ROUND;
    accum_en   = state == ACCUM;
    done       = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      armed      <= 1'b1;
      hash_valid <= 1'b0;
      blk_idx    <= '0;
    end else begin
      state      <= nxt;
      armed      <= accept ? 1'b0 : (!start || armed);
      hash_valid <= nxt == DONE || (hash_valid && nxt != INIT && !kill);
      blk_idx    <= init_hash ? '0 : (accum_en && nxt == LOAD) ? blk_idx + 1'b1 : blk_idx;
    end
  end
endmodule

// File: tb/tb_sha256_ctrl.sv
// tb_sha256_ctrl: directed table-driven bench for one- and two-block sequencing, start re-arm and reset/abort
module tb_sha256_ctrl;
  logic clk = 0, reset = 0, start = 0, start2 = 0;
`ifdef SHA256_CTRL_ABORT_EN
  logic abort = 0, abort2 = 0;
`endif
  logic busy, done, hv, init_hash, load_block, round_en, accum_en;
  logic [0:0] blk_idx;
  logic [5:0] rnd;
  logic busy2, done2, hv2, init2, load2, ren2, acc2;
  logic [0:0] blk2;
  logic [5:0] rnd2;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  sha256_ctrl #(.MSG_SIZE(120), .PADDED_SIZE(512)) u_dut (
    .clk(clk), .reset(reset), .start(start),
`ifdef SHA256_CTRL_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .hash_valid(hv), .init_hash(init_hash), .load_block(load_block),
    .blk_idx(blk_idx), .round_en(round_en), .round(rnd), .accum_en(accum_en));

  sha256_ctrl #(.MSG_SIZE(120), .PADDED_SIZE(1024)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2),
`ifdef SHA256_CTRL_ABORT_EN
    .abort(abort2),
`endif
    .busy(busy2), .done(done2), .hash_valid(hv2), .init_hash(init2), .load_block(load2),
    .blk_idx(blk2), .round_en(ren2), .round(rnd2), .accum_en(acc2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         cyc;
    logic [6:0] flags;
    logic [5:0] rnd;
  } vec_t;
  vec_t tbl[8];

  function automatic logic [6:0] flags1();
    return {busy, init_hash, load_block, round_en, accum_en, done, hv};
  endfunction

  initial begin
    #100us;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int ren_cnt, done_cnt, done2_cnt, load2_cnt, init_cnt;
    // flags = {busy, init_hash, load_block, round_en, accum_en, done, hash_valid}
    tbl[0] = '{1,  7'b1100000, 6'd0};
    tbl[1] = '{2,  7'b1010000, 6'd0};
    tbl[2] = '{3,  7'b1001000, 6'd0};
    tbl[3] = '{4,  7'b1001000, 6'd1};
    tbl[4] = '{66, 7'b1001000, 6'd63};
    tbl[5] = '{67, 7'b1000100, 6'd63};
    tbl[6] = '{68, 7'b1000011, 6'd63};
    tbl[7] = '{69, 7'b0000001, 6'd63};

    repeat (2) @(negedge clk);
    chk("rst_flags_in_reset", 32'(flags1()), 0);
    reset = 1;
    @(negedge clk);
    chk("rst_flags", 32'(flags1()), 0);
    chk("rst_round", rnd, 0);
    chk("rst_blk", blk_idx, 0);
    chk("rst_busy2", busy2, 0);

    // one-block and two-block runs launched together; cycle 0 is acceptance
    start = 1; start2 = 1;
    ren_cnt = 0; done_cnt = 0; done2_cnt = 0; load2_cnt = 0;
    for (int c = 1; c <= 140; c++) begin
      @(negedge clk);
      if (c == 1) begin start = 0; start2 = 0; end
      foreach (tbl[k]) if (tbl[k].cyc == c) begin
        chk($sformatf("tbl_flags_c%0d", c), 32'(flags1()), 32'(tbl[k].flags));
        chk($sformatf("tbl_round_c%0d", c), rnd, tbl[k].rnd);
      end
      if (round_en) begin
        ren_cnt++;
        chk($sformatf("round_seq_c%0d", c), rnd, 32'(c - 3));
      end
      done_cnt += done;
      done2_cnt += done2;
      load2_cnt += load2;
      if (c == 2 || c == 68) begin
        chk($sformatf("b2_load_c%0d", c), load2, 1);
        chk($sformatf("b2_blk_c%0d", c), blk2, c == 68);
      end
      if (c == 133) chk("b2_no_early_done", done2, 0);
      if (c == 134) chk("b2_done_c134", done2, 1);
      if (c == 135) chk("b2_hv", hv2, 1);
    end
    chk("b1_round_en_count", ren_cnt, 64);
    chk("b1_done_count", done_cnt, 1);
    chk("b1_hv_after", hv, 1);
    chk("b2_done_count", done2_cnt, 1);
    chk("b2_load_count", load2_cnt, 2);

    // start held 650 ns: one run only
    start = 1; done_cnt = 0; init_cnt = 0;
    for (int c = 1; c <= 150; c++) begin
      @(negedge clk);
      if (c == 65) start = 0;
      done_cnt += done;
      init_cnt += init_hash;
    end
    chk("hold650_done_count", done_cnt, 1);
    chk("hold650_init_count", init_cnt, 1);
    chk("hold650_idle", busy, 0);

    // start held across DONE: no retrigger until it drops
    start = 1; done_cnt = 0; init_cnt = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      done_cnt += done;
      init_cnt += init_hash;
    end
    chk("hold_done_count", done_cnt, 1);
    chk("hold_init_count", init_cnt, 1);
    chk("hold_no_restart", busy, 0);
    start = 0;
    @(negedge clk);
    start = 1;
    chk("rearm_hv_before", hv, 1);
    @(negedge clk);
    start = 0;
    chk("rearm_init", init_hash, 1);
    chk("rearm_hv_cleared", hv, 0);
    for (int c = 2; c <= 68; c++) @(negedge clk);
    chk("rearm_done_c68", done, 1);
    @(negedge clk);

    // synchronous reset during ROUND
    start = 1; done_cnt = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) start = 0;
    end
    chk("rst_mid_in_round", round_en, 1);
    reset = 0;
    @(negedge clk);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_hv", hv, 0);
    chk("rst_mid_round", rnd, 0);
    reset = 1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      done_cnt += done;
    end
    chk("rst_mid_no_done", done_cnt, 0);
    chk("rst_mid_idle", busy, 0);

`ifdef SHA256_CTRL_ABORT_EN
    start = 1; done_cnt = 0;
    for (int c = 1; c <= 67; c++) begin
      @(negedge clk);
      if (c == 1) start = 0;
    end
    chk("abort_in_accum", accum_en, 1);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_no_done", done, 0);
    chk("abort_hv", hv, 0);
    start = 1;
    for (int c = 1; c <= 68; c++) begin
      @(negedge clk);
      if (c == 1) start = 0;
      if (c < 68) done_cnt += done;
    end
    chk("abort_rerun_no_early_done", done_cnt, 0);
    chk("abort_rerun_done_c68", done, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
